// File: rtl/tpg_pkg.sv
// Shared definitions for the adaptive test-pattern generator.
// Contents:
//   tpg_state_t   - controller state encoding
//   TAPS_*        - Galois feedback masks for common vector widths
//                   (left-shift form: bit i set = x^i term, x^W implied)
//   exp_update()  - expected-fault-count threshold update
package tpg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_WAIT,
        S_EVAL,
        S_EMIT,
        S_DIV,
        S_DONE
    } tpg_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0]  TAPS_16  = 16'h6801;
    // x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0]  TAPS_32  = 32'h0040_0007;
    // x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [63:0]  TAPS_64  = 64'hB000_0000_0000_0001;
    // x^157 + x^156 + x^155 + x^145 + 1
    localparam logic [156:0] TAPS_157 = (157'(1) << 156) | (157'(1) << 155)
                                      | (157'(1) << 145) | 157'(1);

    // The sum is formed at 32 bits, wider than any fault count, so it
    // cannot wrap. The result never exceeds max(n, e).
    function automatic int unsigned exp_update(input int unsigned n,
                                               input int unsigned e);
        if (n < e) begin
            return e >> 1;
        end
        return (n + e) >> 1;
    endfunction

endpackage

// File: rtl/tpg_cov_div.sv
// Restoring divider producing floor(i_dividend / NUM_FAULTS) as a 7-bit
// quotient. The caller guarantees the quotient fits in 7 bits
// (dividend = 100 * detected with detected <= NUM_FAULTS), so the upper
// dividend bits preload the remainder and only 7 iterations are needed.
// Ports:
//   clk, rst    clock, async active-high reset
//   i_start     load dividend and begin (ignored bits: none)
//   i_dividend  CNT_W+7 bit dividend
//   o_done      one-cycle strobe, quotient valid in that cycle
//   o_quot      7-bit quotient
module tpg_cov_div
    import tpg_pkg::*;
#(
    parameter int NUM_FAULTS = 1798,
    parameter int CNT_W      = $clog2(NUM_FAULTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [CNT_W+6:0]   i_dividend,
    output logic               o_done,
    output logic [6:0]         o_quot
);

    logic [CNT_W-1:0] r_rem;
    logic [6:0]       r_low;
    logic [6:0]       r_quot;
    logic [2:0]       r_cnt;
    logic             r_busy;

    logic [CNT_W:0]   w_trial;
    logic             w_ge;

    assign w_trial = {r_rem, r_low[6]};
    assign w_ge    = (w_trial >= (CNT_W+1)'(NUM_FAULTS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_low  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= i_dividend[CNT_W+6:7];
            r_low  <= i_dividend[6:0];
            r_quot <= '0;
            r_cnt  <= 3'd7;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt != 3'd0) begin
                r_rem  <= w_ge ? CNT_W'(w_trial - (CNT_W+1)'(NUM_FAULTS))
                               : CNT_W'(w_trial);
                r_low  <= {r_low[5:0], 1'b0};
                r_quot <= {r_quot[5:0], w_ge};
                r_cnt  <= r_cnt - 3'd1;
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == 3'd0);
    assign o_quot = r_quot;

endmodule

// File: rtl/adaptive_tpg.sv
// Adaptive random test-pattern generator. A Galois LFSR proposes
// candidates, the fault engine reports newly detected faults for each,
// and an adaptive threshold decides which candidates are kept. Kept
// vectors are streamed out and accumulated into a coverage percentage.
// Ports:
//   clk, rst                      clock, async active-high reset
//   i_start, i_seed               start pulse and LFSR seed (0 -> 1)
//   o_cand_valid/i_cand_ready/o_cand_vec   candidate stream
//   i_res_valid, i_res_new        fault-engine result strobe and count
//   o_keep_valid/i_keep_ready/o_keep_vec   kept-vector stream
//   o_busy, o_done                run status
//   o_coverage_pct, o_kept_cnt, o_total_cnt   statistics
//
// state  | meaning
// IDLE   | after reset, waiting for start
// GEN    | first cycle steps LFSR, then offers candidate until accepted
// WAIT   | waiting for the engine's result strobe
// EVAL   | threshold update and keep/reject decision
// EMIT   | offering the kept vector until accepted
// DIV    | coverage percentage division, then stop-or-continue
// DONE   | finished; restartable with start
module adaptive_tpg
    import tpg_pkg::*;
#(
    parameter int               VEC_W      = 157,
    parameter logic [VEC_W-1:0] TAPS       = VEC_W'(1),
    parameter int               NUM_FAULTS = 1798,
    parameter int               INIT_EXP   = 2,
    parameter int               UT_LIMIT   = 20,
    parameter int               COV_PCT    = 90,
    parameter int               CNT_W      = $clog2(NUM_FAULTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [VEC_W-1:0]   i_seed,
    output logic               o_cand_valid,
    input  logic               i_cand_ready,
    output logic [VEC_W-1:0]   o_cand_vec,
    input  logic               i_res_valid,
    input  logic [CNT_W-1:0]   i_res_new,
    output logic               o_keep_valid,
    input  logic               i_keep_ready,
    output logic [VEC_W-1:0]   o_keep_vec,
    output logic               o_busy,
    output logic               o_done,
    output logic [6:0]         o_coverage_pct,
    output logic [15:0]        o_kept_cnt,
    output logic [15:0]        o_total_cnt
);

    localparam int UT_W = $clog2(UT_LIMIT + 1);

    tpg_state_t       r_state, w_next;
    logic [VEC_W-1:0] r_lfsr;
    logic             r_cand_valid;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_exp;
    logic [UT_W-1:0]  r_ut;
    logic [CNT_W-1:0] r_det;
    logic [6:0]       r_cov;
    logic [15:0]      r_kept;
    logic [15:0]      r_total;

    logic [VEC_W-1:0] w_step;
    logic [CNT_W-1:0] w_exp_next;
    logic             w_keep;
    logic [CNT_W:0]   w_det_sum;
    logic [CNT_W-1:0] w_det_next;
    logic [CNT_W+6:0] w_dividend;
    logic             w_div_start;
    logic             w_div_done;
    logic [6:0]       w_quot;

    assign w_step     = {r_lfsr[VEC_W-2:0], 1'b0} ^ (r_lfsr[VEC_W-1] ? TAPS : '0);
    assign w_exp_next = CNT_W'(exp_update(32'(r_n), 32'(r_exp)));
    assign w_keep     = (r_n >= w_exp_next) && (r_n != '0);
    assign w_det_sum  = {1'b0, r_det} + {1'b0, r_n};
    assign w_det_next = (w_det_sum > (CNT_W+1)'(NUM_FAULTS)) ? CNT_W'(NUM_FAULTS)
                                                             : w_det_sum[CNT_W-1:0];
    // r_det is already updated by EVAL when the division is launched.
    assign w_dividend  = (CNT_W+7)'(r_det) * (CNT_W+7)'(100);
    assign w_div_start = (r_state == S_EMIT) && i_keep_ready;

    tpg_cov_div #(
        .NUM_FAULTS (NUM_FAULTS),
        .CNT_W      (CNT_W)
    ) u_cov_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_keep_valid = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_GEN;
            end
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                if (i_start) w_next = S_GEN;
            end
            S_GEN:  if (r_cand_valid && i_cand_ready) w_next = S_WAIT;
            S_WAIT: if (i_res_valid) w_next = S_EVAL;
            S_EVAL: begin
                if (w_keep)                         w_next = S_EMIT;
                else if (r_ut == UT_W'(UT_LIMIT))   w_next = S_DONE;
                else                                w_next = S_GEN;
            end
            S_EMIT: begin
                o_keep_valid = 1'b1;
                if (i_keep_ready) w_next = S_DIV;
            end
            S_DIV: begin
                if (w_div_done) w_next = (w_quot >= 7'(COV_PCT)) ? S_DONE : S_GEN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr       <= VEC_W'(1);
            r_cand_valid <= 1'b0;
            r_n          <= '0;
            r_exp        <= CNT_W'(INIT_EXP);
            r_ut         <= '0;
            r_det        <= '0;
            r_cov        <= '0;
            r_kept       <= '0;
            r_total      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_lfsr  <= (i_seed == '0) ? VEC_W'(1) : i_seed;
                        r_exp   <= CNT_W'(INIT_EXP);
                        r_ut    <= '0;
                        r_det   <= '0;
                        r_cov   <= '0;
                        r_kept  <= '0;
                        r_total <= '0;
                    end
                end
                S_GEN: begin
                    // r_cand_valid low marks the step cycle on GEN entry.
                    if (!r_cand_valid) begin
                        r_lfsr       <= w_step;
                        r_cand_valid <= 1'b1;
                        r_ut         <= r_ut + UT_W'(1);
                        if (r_total != 16'hFFFF) r_total <= r_total + 16'd1;
                    end else if (i_cand_ready) begin
                        r_cand_valid <= 1'b0;
                    end
                end
                S_WAIT: if (i_res_valid) r_n <= i_res_new;
                S_EVAL: begin
                    r_exp <= w_exp_next;
                    if (w_keep) begin
                        r_ut  <= '0;
                        r_det <= w_det_next;
                        if (r_kept != 16'hFFFF) r_kept <= r_kept + 16'd1;
                    end
                end
                S_DIV: if (w_div_done) r_cov <= w_quot;
                default: ;
            endcase
        end
    end

    assign o_cand_valid   = r_cand_valid;
    assign o_cand_vec     = r_cand_valid ? r_lfsr : '0;
    assign o_keep_vec     = (r_state == S_EMIT) ? r_lfsr : '0;
    assign o_coverage_pct = r_cov;
    assign o_kept_cnt     = r_kept;
    assign o_total_cnt    = r_total;

endmodule

// File: tb/tb_adaptive_tpg.sv
// Directed bench for adaptive_tpg: 16-bit LFSR (x^16+x^14+x^13+x^11+1),
// 100 faults, INIT_EXP=2, UT_LIMIT=3, COV_PCT=90.
// Expected LFSR sequence from seed 0x8001, hand-computed:
//   6803, D006, C80D, F81B, 9837, 586F ; from seed 0 (->1): 0002, 0004
module tb_adaptive_tpg;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic        cand_valid;
    logic        cand_ready;
    logic [15:0] cand_vec;
    logic        res_valid;
    logic [6:0]  res_new;
    logic        keep_valid;
    logic        keep_ready;
    logic [15:0] keep_vec;
    logic        busy;
    logic        done;
    logic [6:0]  coverage_pct;
    logic [15:0] kept_cnt;
    logic [15:0] total_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adaptive_tpg #(
        .VEC_W      (16),
        .TAPS       (16'h6801),
        .NUM_FAULTS (100),
        .INIT_EXP   (2),
        .UT_LIMIT   (3),
        .COV_PCT    (90)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_seed         (seed),
        .o_cand_valid   (cand_valid),
        .i_cand_ready   (cand_ready),
        .o_cand_vec     (cand_vec),
        .i_res_valid    (res_valid),
        .i_res_new      (res_new),
        .o_keep_valid   (keep_valid),
        .i_keep_ready   (keep_ready),
        .o_keep_vec     (keep_vec),
        .o_busy         (busy),
        .o_done         (done),
        .o_coverage_pct (coverage_pct),
        .o_kept_cnt     (kept_cnt),
        .o_total_cnt    (total_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return cand_valid;
            1:       return keep_valid;
            default: return done;
        endcase
    endfunction

    // Counts negedges until the selected signal is high (0 if already high).
    task automatic wait_for(input int which, input string tag, output int cyc);
        cyc = 0;
        while (!sel(which) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!sel(which)) check_eq({tag, " timeout"}, 32'(sel(which)), 32'd1);
    endtask

    task automatic pulse_start(input logic [15:0] s);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a candidate, checks it, returns result n once accepted.
    // Returns at the negedge of the EVAL cycle, or of EMIT when kept.
    task automatic do_cand(input string tag, input logic [15:0] vec,
                           input int n, input bit keep);
        int cyc;
        wait_for(0, tag, cyc);
        check_eq({tag, " cand_vec"}, 32'(cand_vec), 32'(vec));
        @(negedge clk);
        res_valid = 1'b1;
        res_new   = 7'(n);
        @(negedge clk);
        res_valid = 1'b0;
        if (keep) begin
            wait_for(1, tag, cyc);
            check_eq({tag, " res->keep lat"}, 32'(cyc), 32'd1);
            check_eq({tag, " keep_vec"}, 32'(keep_vec), 32'(vec));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; seed = '0; cand_ready = 1'b1;
        res_valid = 1'b0; res_new = '0; keep_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst cand_valid", 32'(cand_valid), 32'd0);
        check_eq("rst busy",       32'(busy),       32'd0);
        check_eq("rst done",       32'(done),       32'd0);
        check_eq("rst total",      32'(total_cnt),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Threshold update: n=5,0,1 -> exp 3,1,1; keep, reject, keep.
        pulse_start(16'h8001);
        check_eq("t1 busy", 32'(busy), 32'd1);
        do_cand("t1c1", 16'h6803, 5, 1'b1);
        check_eq("t1 kept after c1", 32'(kept_cnt), 32'd1);
        wait_for(0, "t1 keep->cand", cyc);
        check_eq("t1 keep hs->cand lat", 32'(cyc), 32'd10);
        check_eq("t1 cov 5", 32'(coverage_pct), 32'd5);
        do_cand("t1c2", 16'hD006, 0, 1'b0);
        wait_for(0, "t1 rej->cand", cyc);
        check_eq("t1 rej->cand lat", 32'(cyc), 32'd2);
        check_eq("t1 kept after c2", 32'(kept_cnt), 32'd1);
        do_cand("t1c3", 16'hC80D, 1, 1'b1);
        check_eq("t1 kept after c3", 32'(kept_cnt), 32'd2);
        wait_for(0, "t1 c3->cand", cyc);
        check_eq("t1 cov 6", 32'(coverage_pct), 32'd6);
        // exp falls to 0; n=0 is still rejected; third reject stops.
        do_cand("t1c4", 16'hF81B, 0, 1'b0);
        do_cand("t1c5", 16'h9837, 0, 1'b0);
        do_cand("t1c6", 16'h586F, 0, 1'b0);
        wait_for(2, "t1 done", cyc);
        check_eq("t1 rej->done lat", 32'(cyc), 32'd1);
        check_eq("t1 busy",  32'(busy),         32'd0);
        check_eq("t1 kept",  32'(kept_cnt),     32'd2);
        check_eq("t1 total", 32'(total_cnt),    32'd6);
        check_eq("t1 cov",   32'(coverage_pct), 32'd6);

        // Reject limit from a fresh start: exactly 3 candidates.
        pulse_start(16'h8001);
        check_eq("t2 done cleared", 32'(done),      32'd0);
        check_eq("t2 kept cleared", 32'(kept_cnt),  32'd0);
        check_eq("t2 cov cleared",  32'(coverage_pct), 32'd0);
        do_cand("t2c1", 16'h6803, 0, 1'b0);
        do_cand("t2c2", 16'hD006, 0, 1'b0);
        do_cand("t2c3", 16'hC80D, 0, 1'b0);
        wait_for(2, "t2 done", cyc);
        check_eq("t2 done",  32'(done),         32'd1);
        check_eq("t2 kept",  32'(kept_cnt),     32'd0);
        check_eq("t2 total", 32'(total_cnt),    32'd3);
        check_eq("t2 cov",   32'(coverage_pct), 32'd0);

        // Seed 0, backpressure, stray strobes, coverage stop.
        pulse_start(16'h0000);
        do_cand("t3c1", 16'h0002, 50, 1'b1);
        cand_ready = 1'b0;
        wait_for(0, "t3 cand2", cyc);
        check_eq("t3 cov 50", 32'(coverage_pct), 32'd50);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin res_valid = 1'b1; res_new = 7'd99; end
            if (i == 4) res_valid = 1'b0;
            if (i == 6) begin start = 1'b1; seed = 16'h1234; end
            if (i == 7) start = 1'b0;
            @(negedge clk);
            check_eq("t3 bp cand_vec", 32'(cand_vec),  32'h0004);
            check_eq("t3 bp total",    32'(total_cnt), 32'd2);
        end
        cand_ready = 1'b1;
        keep_ready = 1'b0;
        do_cand("t3c2", 16'h0004, 40, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t3 bp keep_valid", 32'(keep_valid),   32'd1);
            check_eq("t3 bp keep_vec",   32'(keep_vec),     32'h0004);
            check_eq("t3 bp kept",       32'(kept_cnt),     32'd2);
            check_eq("t3 bp cov",        32'(coverage_pct), 32'd50);
        end
        keep_ready = 1'b1;
        wait_for(2, "t3 done", cyc);
        check_eq("t3 keep hs->done lat", 32'(cyc), 32'd9);
        check_eq("t3 cov 90", 32'(coverage_pct), 32'd90);
        check_eq("t3 total",  32'(total_cnt),    32'd2);
        check_eq("t3 kept",   32'(kept_cnt),     32'd2);

        // Reset while a kept vector is held in EMIT.
        keep_ready = 1'b0;
        pulse_start(16'h8001);
        do_cand("t4c1", 16'h6803, 5, 1'b1);
        @(negedge clk);
        check_eq("t4 pre-rst keep_valid", 32'(keep_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t4 rst keep_valid", 32'(keep_valid),   32'd0);
        check_eq("t4 rst keep_vec",   32'(keep_vec),     32'd0);
        check_eq("t4 rst cand_vec",   32'(cand_vec),     32'd0);
        check_eq("t4 rst busy",       32'(busy),         32'd0);
        check_eq("t4 rst kept",       32'(kept_cnt),     32'd0);
        check_eq("t4 rst total",      32'(total_cnt),    32'd0);
        check_eq("t4 rst cov",        32'(coverage_pct), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        keep_ready = 1'b1;
        @(negedge clk);
        pulse_start(16'h8001);
        do_cand("t4r1", 16'h6803, 0, 1'b0);
        do_cand("t4r2", 16'hD006, 0, 1'b0);
        check_eq("t4 restart total", 32'(total_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
